// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

   localparam int unsigned IRQ_MAX        = 16;
   localparam int unsigned IRQ_CAUSE_BASE = 16;
   localparam int unsigned MCAUSE_INT_BIT = 31;
   localparam int unsigned IDX_W          = 4;

   typedef enum logic [1:0] {
      StIdle,
      StExc,
      StIrq,
      StIrqExc
   } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest set index of the masked request vector wins.
module irq_priority_encoder
   import irq_pkg::*;
#(
   parameter int unsigned IRQ_NUM = 16
) (
   input  logic [IRQ_NUM-1:0] masked_i,
   output logic [IDX_W-1:0]   sel_idx_o,
   output logic               any_o
);

   // Scan downwards so the final assignment is the lowest set bit.
   always_comb begin
      sel_idx_o = '0;
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (masked_i[i]) begin
            sel_idx_o = IDX_W'(i);
         end
      end
   end

   assign any_o = |masked_i;

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller with exception nesting and mret acknowledge.
// Define IRQ_EDGE_LATCH_EN for sticky rising-edge request capture; default is level-sensitive.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned IRQ_NUM = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               exception_i,
   input  logic               mret_i,
   input  logic [31:0]        mie_i,
   input  logic [IRQ_NUM-1:0] irq_req_i,
   output logic               irq_o,
   output logic [31:0]        irq_cause_o,
   output logic [IRQ_NUM-1:0] irq_ret_o
);

   irq_state_t         state_q, state_d;
   logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
   logic [IDX_W-1:0]   sel_idx;
   logic [IRQ_NUM-1:0] pend;
   logic [IRQ_NUM-1:0] masked;
   logic               any;
   logic               ret_fire;
   logic [31:0]        cause_val;
   logic               unused_mie;

   // Only the external-interrupt enable bits are consulted.
   assign unused_mie = ^mie_i;

`ifdef IRQ_EDGE_LATCH_EN
   logic [IRQ_NUM-1:0] req_q;
   logic [IRQ_NUM-1:0] pend_q, pend_d;

   // A fresh edge in the acknowledge cycle wins over the clear.
   assign pend_d = (pend_q & ~irq_ret_o) | (irq_req_i & ~req_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q  <= '0;
         pend_q <= '0;
      end else begin
         req_q  <= irq_req_i;
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;
`else
   assign pend = irq_req_i;
`endif

   assign masked = pend & mie_i[IRQ_CAUSE_BASE +: IRQ_NUM];

   irq_priority_encoder #(
      .IRQ_NUM (IRQ_NUM)
   ) u_prio (
      .masked_i  (masked),
      .sel_idx_o (sel_idx),
      .any_o     (any)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cur_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cur_idx_q <= cur_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_idx_d = cur_idx_q;
      ret_fire  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (exception_i) begin
               state_d = StExc;
            end else if (any) begin
               state_d   = StIrq;
               cur_idx_d = sel_idx;
            end
         end
         StExc: begin
            if (!exception_i && mret_i) begin
               state_d = StIdle;
            end
         end
         StIrq: begin
            if (exception_i) begin
               state_d = StIrqExc;
            end else if (mret_i) begin
               state_d  = StIdle;
               ret_fire = rst_ni;
            end
         end
         StIrqExc: begin
            if (!exception_i && mret_i) begin
               state_d = StIrq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Combinational so the CSR block captures the current PC in the same cycle.
   assign irq_o       = rst_ni & (state_q == StIdle) & any & ~exception_i;
   assign cause_val   = 32'(IRQ_CAUSE_BASE) + 32'(sel_idx);
   assign irq_cause_o = irq_o ? (cause_val | (32'd1 << MCAUSE_INT_BIT)) : 32'd0;
   assign irq_ret_o   = ret_fire ? (IRQ_NUM'(1) << cur_idx_q) : '0;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (level-sensitive build).
module tb_irq_controller;

   localparam int unsigned IRQ_NUM = 16;

   logic               clk_i;
   logic               rst_ni;
   logic               exception_i;
   logic               mret_i;
   logic [31:0]        mie_i;
   logic [IRQ_NUM-1:0] irq_req_i;
   logic               irq_o;
   logic [31:0]        irq_cause_o;
   logic [IRQ_NUM-1:0] irq_ret_o;

   int n_vec;
   int n_err;

   irq_controller #(
      .IRQ_NUM (IRQ_NUM)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .exception_i (exception_i),
      .mret_i      (mret_i),
      .mie_i       (mie_i),
      .irq_req_i   (irq_req_i),
      .irq_o       (irq_o),
      .irq_cause_o (irq_cause_o),
      .irq_ret_o   (irq_ret_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs settle 1ns later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Sample combinational outputs mid-cycle, well away from the edge.
   task automatic expect_out(input string tag, input logic irq, input logic [31:0] cause,
                             input logic [15:0] ret);
      #2;
      check({tag, ".irq"},   32'(irq_o),     32'(irq));
      check({tag, ".cause"}, irq_cause_o,    cause);
      check({tag, ".ret"},   32'(irq_ret_o), 32'(ret));
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst_ni      = 1'b0;
      exception_i = 1'b0;
      mret_i      = 1'b0;
      mie_i       = 32'hFFFF_FFFF;
      irq_req_i   = 16'hFFFF;

      // Reset forces outputs low even with every line requesting.
      #3;
      expect_out("rst_hold", 1'b0, 32'h0, 16'h0);
      step();
      step();
      rst_ni = 1'b0;
      expect_out("rst_hold2", 1'b0, 32'h0, 16'h0);
      rst_ni = 1'b1;
      expect_out("rst_release", 1'b1, 32'h8000_0010, 16'h0);
      step();
      expect_out("rst_inirq", 1'b0, 32'h0, 16'h0);
      mret_i    = 1'b1;
      irq_req_i = 16'h0;
      expect_out("rst_ack", 1'b0, 32'h0, 16'h0001);
      step();
      mret_i = 1'b0;
      expect_out("rst_idle", 1'b0, 32'h0, 16'h0);

      // mret in IDLE is ignored.
      mret_i = 1'b1;
      expect_out("idle_mret", 1'b0, 32'h0, 16'h0);
      step();
      mret_i = 1'b0;

      // Priority: lines 3 and 7, lowest wins.
      mie_i     = (32'd1 << 19) | (32'd1 << 23);
      irq_req_i = 16'h0088;
      expect_out("prio_take3", 1'b1, 32'h8000_0013, 16'h0);
      step();
      expect_out("prio_once", 1'b0, 32'h0, 16'h0);
      step();
      mret_i    = 1'b1;
      irq_req_i = 16'h0080;
      expect_out("prio_ack3", 1'b0, 32'h0, 16'h0008);
      step();
      mret_i = 1'b0;
      expect_out("prio_take7", 1'b1, 32'h8000_0017, 16'h0);
      step();
      mret_i    = 1'b1;
      irq_req_i = 16'h0;
      expect_out("prio_ack7", 1'b0, 32'h0, 16'h0080);
      step();
      mret_i = 1'b0;

      // Masking: line 5 blocked until its enable bit is set.
      irq_req_i = 16'h0020;
      mie_i     = 32'h0;
      expect_out("mask_off", 1'b0, 32'h0, 16'h0);
      step();
      expect_out("mask_off2", 1'b0, 32'h0, 16'h0);
      mie_i = 32'd1 << 21;
      expect_out("mask_on", 1'b1, 32'h8000_0015, 16'h0);
      step();
      mie_i  = 32'h0;
      mret_i = 1'b1;
      expect_out("mask_ack", 1'b0, 32'h0, 16'h0020);
      irq_req_i = 16'h0;
      step();
      mret_i = 1'b0;

      // Nesting: exception inside an interrupt handler.
      irq_req_i = 16'h0004;
      mie_i     = 32'd1 << 18;
      expect_out("nest_take", 1'b1, 32'h8000_0012, 16'h0);
      step();
      exception_i = 1'b1;
      expect_out("nest_exc", 1'b0, 32'h0, 16'h0);
      step();
      exception_i = 1'b0;
      mret_i      = 1'b1;
      expect_out("nest_mret1", 1'b0, 32'h0, 16'h0);
      step();
      expect_out("nest_mret2", 1'b0, 32'h0, 16'h0004);
      irq_req_i = 16'h0;
      step();
      mret_i = 1'b0;
      expect_out("nest_idle", 1'b0, 32'h0, 16'h0);

      // Collision: exception beats a pending interrupt in IDLE.
      irq_req_i   = 16'h0002;
      mie_i       = 32'd1 << 17;
      exception_i = 1'b1;
      expect_out("coll_exc", 1'b0, 32'h0, 16'h0);
      step();
      exception_i = 1'b0;
      expect_out("coll_inexc", 1'b0, 32'h0, 16'h0);
      mret_i = 1'b1;
      expect_out("coll_mret", 1'b0, 32'h0, 16'h0);
      step();
      mret_i = 1'b0;
      expect_out("coll_take", 1'b1, 32'h8000_0011, 16'h0);
      step();
      // Exception has priority over mret inside the handler.
      exception_i = 1'b1;
      mret_i      = 1'b1;
      expect_out("coll_excmret", 1'b0, 32'h0, 16'h0);
      step();
      exception_i = 1'b0;
      step();
      expect_out("coll_ack", 1'b0, 32'h0, 16'h0002);
      irq_req_i = 16'h0;
      step();
      mret_i = 1'b0;

      // Asynchronous reset mid-handler clears state and current index.
      irq_req_i = 16'h0200;
      mie_i     = 32'd1 << 25;
      expect_out("ar_take", 1'b1, 32'h8000_0019, 16'h0);
      step();
      rst_ni = 1'b0;
      mret_i = 1'b1;
      expect_out("ar_assert", 1'b0, 32'h0, 16'h0);
      mret_i = 1'b0;
      step();
      rst_ni = 1'b1;
      expect_out("ar_release", 1'b1, 32'h8000_0019, 16'h0);
      step();
      mret_i = 1'b1;
      expect_out("ar_ack", 1'b0, 32'h0, 16'h0200);
      irq_req_i = 16'h0;
      step();
      mret_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
